// File: rtl/glyph_stream_gen.sv
// rtl/glyph_stream_gen.sv - big-glyph ROM address walker and byte streamer for the OLED text path
module glyph_stream_gen #(
   parameter int GLYPH_W     = 24,
   parameter int GLYPH_PAGES = 6,
   parameter int START_PAGE  = 2,
   parameter int START_COL   = 0,
   parameter int NUM_CHARS   = 4,
   parameter int ASCII_W     = 7,
   parameter int COL_W       = 5,
   parameter int PAGE_W      = 3,
   parameter int SLOT_W      = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic                             invert,
   input  logic                             abort,
   output logic                             busy,
   output logic                             done,
   output logic [SLOT_W-1:0]                char_idx,
   input  logic [ASCII_W-1:0]               char_ascii,
   output logic [ASCII_W+PAGE_W+COL_W-1:0]  rom_addr,
   output logic                             rom_en,
   input  logic [7:0]                       rom_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [7:0]                       out_data,
   output logic [2:0]                       out_page,
   output logic [10:0]                      out_col
);

   localparam logic [COL_W-1:0]   C_LAST = COL_W'(GLYPH_W - 1);
   localparam logic [SLOT_W-1:0]  S_LAST = SLOT_W'(NUM_CHARS - 1);
   localparam logic [PAGE_W-1:0]  P_LAST = PAGE_W'(GLYPH_PAGES - 1);
   localparam logic [10:0]        COL0   = 11'(START_COL);
   localparam logic [2:0]         PAGE0  = 3'(START_PAGE);
   localparam logic [ASCII_W-1:0] SPACE  = ASCII_W'(32);

   generate
      if (START_COL + NUM_CHARS * GLYPH_W > 128) begin : g_bad_geometry
         $error("glyph window exceeds 128 OLED columns");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

   state_t              state_q, state_d;
   logic [COL_W-1:0]    c_q, c_d;
   logic [SLOT_W-1:0]   s_q, s_d;
   logic [PAGE_W-1:0]   p_q, p_d;
   logic [10:0]         acol_q, acol_d;
   logic                inv_q, inv_d;
   logic                done_q, done_d;
   logic                advance;

   logic                b_valid_q, b_space_q;
   logic [2:0]          b_page_q;
   logic [10:0]         b_col_q;
   logic                out_valid_q;
   logic [7:0]          out_data_q;
   logic [2:0]          out_page_q;
   logic [10:0]         out_col_q;

   // A full output register with no taker freezes every stage, ROM included.
   assign advance   = !out_valid_q || out_ready;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign char_idx  = s_q;
   assign rom_addr  = (state_q == S_RUN) ? {char_ascii, p_q, c_q} : '0;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_page  = out_page_q;
   assign out_col   = out_col_q;

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      s_d     = s_q;
      p_d     = p_q;
      acol_d  = acol_q;
      inv_d   = inv_q;
      done_d  = 1'b0;
      rom_en  = 1'b0;
      if (abort) begin
         state_d = S_IDLE;
         c_d     = '0;
         s_d     = '0;
         p_d     = '0;
         acol_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_RUN;
                  c_d     = '0;
                  s_d     = '0;
                  p_d     = '0;
                  acol_d  = COL0;
                  inv_d   = invert;
               end
            end
            S_RUN: begin
               if (advance) begin
                  rom_en = 1'b1;
                  if (c_q == C_LAST) begin
                     c_d = '0;
                     if (s_q == S_LAST) begin
                        s_d    = '0;
                        acol_d = COL0;
                        if (p_q == P_LAST) begin
                           p_d     = '0;
                           state_d = S_FLUSH;
                        end else begin
                           p_d = p_q + 1'b1;
                        end
                     end else begin
                        s_d    = s_q + 1'b1;
                        acol_d = acol_q + 11'd1;
                     end
                  end else begin
                     c_d    = c_q + 1'b1;
                     acol_d = acol_q + 11'd1;
                  end
               end
            end
            S_FLUSH: begin
               // Stage B empty means the beat being accepted is the final one.
               if (out_valid_q && out_ready && !b_valid_q) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         c_q         <= '0;
         s_q         <= '0;
         p_q         <= '0;
         acol_q      <= '0;
         inv_q       <= 1'b0;
         done_q      <= 1'b0;
         b_valid_q   <= 1'b0;
         b_space_q   <= 1'b0;
         b_page_q    <= '0;
         b_col_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_page_q  <= '0;
         out_col_q   <= '0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         s_q     <= s_d;
         p_q     <= p_d;
         acol_q  <= acol_d;
         inv_q   <= inv_d;
         done_q  <= done_d;
         if (abort) begin
            b_valid_q   <= 1'b0;
            out_valid_q <= 1'b0;
         end else if (advance) begin
            b_valid_q   <= rom_en;
            b_space_q   <= (char_ascii == SPACE);
            b_page_q    <= PAGE0 + 3'(p_q);
            b_col_q     <= acol_q;
            out_valid_q <= b_valid_q;
            if (b_valid_q) begin
               out_data_q <= b_space_q ? {8{inv_q}} : (rom_data ^ {8{inv_q}});
               out_page_q <= b_page_q;
               out_col_q  <= b_col_q;
            end
         end
      end
   end

endmodule
